id_ex_stage: RTL and testbench

- ID/EX pipeline register of the 5-stage MIPS core, plus a load-use interlock.
- Captures decoded fields from ID and presents them to EX: the forwarding selector, operand muxes and ALU.
- Inserts bubbles on load-use hazards, taken-branch/jump flushes and syscall halt.
- Keeps saturating stall/flush performance counters.

---
 rtl/mips_pkg.sv | 26 ++
 rtl/id_ex_stage_if.sv | 50 +++++
 rtl/hazard_detect.sv | 16 +
 rtl/id_ex_stage.sv | 84 ++++++++
 tb/tb_id_ex_stage.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: shared control bundle, opcode and jump encodings for the 5-stage MIPS core.
package mips_pkg;
   typedef struct packed {
      logic [3:0] ALUOp;
      logic       RegWrite;
      logic       MemRead;
      logic       MemWrite;
      logic       MemtoReg;
      logic       ALUSrc;
      logic [1:0] Jump;
      logic       Syscall;
   } ctrl_t;
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [1:0] J_NONE   = 2'b00;
   localparam logic [1:0] J_BR     = 2'b01;
   localparam logic [1:0] J_J      = 2'b10;
   localparam logic [1:0] J_JAL    = 2'b11;
   localparam ctrl_t BUBBLE_CTRL   = '0;
endpackage

// File: rtl/id_ex_stage_if.sv
// id_ex_stage_if: ID-side inputs and EX-side outputs of the ID/EX pipeline register.
interface id_ex_stage_if
   import mips_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int REG_W  = 5,
   parameter int CNT_W  = 32
);
   logic [31:0]       instr_id;
   logic [DATA_W-1:0] pc_id;
   logic [DATA_W-1:0] rs_data_id;
   logic [DATA_W-1:0] rt_data_id;
   logic [DATA_W-1:0] imm_ext_id;
   logic [REG_W-1:0]  read_num1_id;
   logic [REG_W-1:0]  read_num2_id;
   logic              use_rs_id;
   logic              use_rt_id;
   logic [REG_W-1:0]  write_num_id;
   ctrl_t             ctrl_id;
   logic              valid_id;
   logic              flush_ex;
   logic              stall_ext;
   logic              halt;
   logic [31:0]       instr_ex;
   logic [DATA_W-1:0] pc_ex;
   logic [DATA_W-1:0] rs_data_ex;
   logic [DATA_W-1:0] rt_data_ex;
   logic [DATA_W-1:0] imm_ext_ex;
   logic [REG_W-1:0]  read_num1_ex;
   logic [REG_W-1:0]  read_num2_ex;
   logic [REG_W-1:0]  write_num_ex;
   ctrl_t             ctrl_ex;
   logic [1:0]        Jump_ex;
   logic              valid_ex;
   logic              stall_if_id;
   logic [CNT_W-1:0]  stall_cycles;
   logic [CNT_W-1:0]  flush_cycles;
   modport master (
      output instr_id, pc_id, rs_data_id, rt_data_id, imm_ext_id, read_num1_id, read_num2_id,
             use_rs_id, use_rt_id, write_num_id, ctrl_id, valid_id, flush_ex, stall_ext, halt,
      input  instr_ex, pc_ex, rs_data_ex, rt_data_ex, imm_ext_ex, read_num1_ex, read_num2_ex,
             write_num_ex, ctrl_ex, Jump_ex, valid_ex, stall_if_id, stall_cycles, flush_cycles
   );
   modport slave (
      input  instr_id, pc_id, rs_data_id, rt_data_id, imm_ext_id, read_num1_id, read_num2_id,
             use_rs_id, use_rt_id, write_num_id, ctrl_id, valid_id, flush_ex, stall_ext, halt,
      output instr_ex, pc_ex, rs_data_ex, rt_data_ex, imm_ext_ex, read_num1_ex, read_num2_ex,
             write_num_ex, ctrl_ex, Jump_ex, valid_ex, stall_if_id, stall_cycles, flush_cycles
   );
endinterface

// File: rtl/hazard_detect.sv
// hazard_detect: flags a load in EX whose destination is read by the instruction in ID.
module hazard_detect #(
   parameter int REG_W = 5
) (
   input  logic             valid_ex,
   input  logic             memread_ex,
   input  logic [REG_W-1:0] write_num_ex,
   input  logic [REG_W-1:0] read_num1,
   input  logic [REG_W-1:0] read_num2,
   input  logic             use_rs,
   input  logic             use_rt,
   output logic             lu
);
   assign lu = valid_ex & memread_ex & (write_num_ex != '0) &
               ((use_rs & (read_num1 == write_num_ex)) | (use_rt & (read_num2 == write_num_ex)));
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use interlock, flush/halt bubbles
// and saturating stall/flush counters.
module id_ex_stage
   import mips_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int REG_W  = 5,
   parameter int CNT_W  = 32
) (
   input logic          clk,
   input logic          rst_n,
   id_ex_stage_if.slave bus
);
   localparam logic [1:0] RUN       = 2'd0;
   localparam logic [1:0] LU_BUBBLE = 2'd1;
   localparam logic [1:0] HALTED    = 2'd2;
   logic [1:0]       state;
   logic             lu;
   logic             halted_q;
   logic             lu_go;
   logic             lu_bub;
   logic [CNT_W-1:0] stall_q;
   logic [CNT_W-1:0] flush_q;
   hazard_detect #(.REG_W(REG_W)) u_hazard (
      .valid_ex     (bus.valid_ex),
      .memread_ex   (bus.ctrl_ex.MemRead),
      .write_num_ex (bus.write_num_ex),
      .read_num1    (bus.read_num1_id),
      .read_num2    (bus.read_num2_id),
      .use_rs       (bus.use_rs_id),
      .use_rt       (bus.use_rt_id),
      .lu           (lu)
   );
   assign halted_q         = state == HALTED;
   assign lu_go            = lu & ~bus.flush_ex & ~halted_q & (state == RUN);
   assign lu_bub           = lu_go & ~bus.stall_ext;
   assign bus.stall_if_id  = rst_n & (lu_go | bus.stall_ext);
   assign bus.Jump_ex      = bus.ctrl_ex.Jump;
   assign bus.stall_cycles = stall_q;
   assign bus.flush_cycles = flush_q;
   always_ff @(posedge clk) begin
      if (!rst_n)
         state <= RUN;
      else if (bus.halt || halted_q)
         state <= HALTED;
      else
         state <= lu_bub ? LU_BUBBLE : RUN;
   end
   // A load-use bubble is suppressed by stall_ext, which holds the register instead.
   always_ff @(posedge clk) begin
      if (!rst_n || bus.flush_ex || halted_q || (!bus.stall_ext && lu)) begin
         bus.instr_ex     <= '0;
         bus.pc_ex        <= '0;
         bus.rs_data_ex   <= '0;
         bus.rt_data_ex   <= '0;
         bus.imm_ext_ex   <= '0;
         bus.read_num1_ex <= '0;
         bus.read_num2_ex <= '0;
         bus.write_num_ex <= '0;
         bus.ctrl_ex      <= BUBBLE_CTRL;
         bus.valid_ex     <= 1'b0;
      end else if (!bus.stall_ext) begin
         bus.instr_ex     <= bus.instr_id;
         bus.pc_ex        <= bus.pc_id;
         bus.rs_data_ex   <= bus.rs_data_id;
         bus.rt_data_ex   <= bus.rt_data_id;
         bus.imm_ext_ex   <= bus.imm_ext_id;
         bus.read_num1_ex <= bus.read_num1_id;
         bus.read_num2_ex <= bus.read_num2_id;
         bus.write_num_ex <= bus.write_num_id;
         bus.ctrl_ex      <= bus.ctrl_id;
         bus.valid_ex     <= bus.valid_id;
      end
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stall_q <= '0;
         flush_q <= '0;
      end else begin
         if (lu_bub && !(&stall_q)) stall_q <= stall_q + CNT_W'(1);
         if (bus.flush_ex && !(&flush_q)) flush_q <= flush_q + CNT_W'(1);
      end
   end
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed and randomized checks of id_ex_stage against a cycle-level model.
module tb_id_ex_stage;
   import mips_pkg::*;
   localparam int CW  = 4;
   localparam int SAT = (1 << CW) - 1;
   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
      logic [31:0] rs;
      logic [31:0] rt;
      logic [31:0] imm;
      logic [4:0]  r1;
      logic [4:0]  r2;
      logic [4:0]  wn;
      ctrl_t       c;
      logic        v;
   } ex_rec_t;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int total = 0;
   int bad = 0;
   ex_rec_t m = '0;
   bit m_halt = 0;
   bit m_pend = 0;
   int m_sc = 0;
   int m_fc = 0;
   always #5 clk = ~clk;
   id_ex_stage_if #(.DATA_W(32), .REG_W(5), .CNT_W(CW)) bus ();
   id_ex_stage #(.DATA_W(32), .REG_W(5), .CNT_W(CW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask
   task automatic rand_id();
      logic [11:0] c;
      c = 12'($urandom);
      bus.instr_id     = $urandom;
      bus.pc_id        = $urandom;
      bus.rs_data_id   = $urandom;
      bus.rt_data_id   = $urandom;
      bus.imm_ext_id   = $urandom;
      bus.read_num1_id = 5'($urandom);
      bus.read_num2_id = 5'($urandom);
      bus.write_num_id = 5'($urandom);
      bus.use_rs_id    = 1'($urandom);
      bus.use_rt_id    = 1'($urandom);
      bus.ctrl_id      = c;
      bus.valid_id     = 1'b1;
   endtask
   task automatic set_ctl(input bit f, input bit s, input bit h);
      bus.flush_ex  = f;
      bus.stall_ext = s;
      bus.halt      = h;
   endtask
   task automatic tick();
      bit l;
      bit lub;
      ex_rec_t id;
      #1;
      l = m.v && m.c.MemRead && m.wn != 0 &&
          ((bus.use_rs_id && bus.read_num1_id == m.wn) || (bus.use_rt_id && bus.read_num2_id == m.wn));
      chk("stall_if_id", bus.stall_if_id,
          rst_n && ((l && !bus.flush_ex && !m_halt && !m_pend) || bus.stall_ext));
      id = '{instr: bus.instr_id, pc: bus.pc_id, rs: bus.rs_data_id, rt: bus.rt_data_id,
             imm: bus.imm_ext_id, r1: bus.read_num1_id, r2: bus.read_num2_id,
             wn: bus.write_num_id, c: bus.ctrl_id, v: bus.valid_id};
      @(posedge clk);
      if (!rst_n) begin
         m = '0; m_halt = 0; m_pend = 0; m_sc = 0; m_fc = 0;
      end else begin
         lub = !m_halt && !m_pend && l && !bus.flush_ex && !bus.stall_ext;
         if (bus.flush_ex) m_fc = (m_fc == SAT) ? SAT : m_fc + 1;
         if (lub) m_sc = (m_sc == SAT) ? SAT : m_sc + 1;
         if (bus.flush_ex || m_halt || (l && !bus.stall_ext)) m = '0;
         else if (!bus.stall_ext) m = id;
         m_pend = lub;
         m_halt = m_halt | bus.halt;
      end
      #1;
      chk("instr_ex", bus.instr_ex, m.instr);
      chk("pc_ex", bus.pc_ex, m.pc);
      chk("rs_data_ex", bus.rs_data_ex, m.rs);
      chk("rt_data_ex", bus.rt_data_ex, m.rt);
      chk("imm_ext_ex", bus.imm_ext_ex, m.imm);
      chk("read_num1_ex", bus.read_num1_ex, m.r1);
      chk("read_num2_ex", bus.read_num2_ex, m.r2);
      chk("write_num_ex", bus.write_num_ex, m.wn);
      chk("ctrl_ex", bus.ctrl_ex, m.c);
      chk("Jump_ex", bus.Jump_ex, m.c.Jump);
      chk("valid_ex", bus.valid_ex, m.v);
      chk("stall_cycles", bus.stall_cycles, m_sc);
      chk("flush_cycles", bus.flush_cycles, m_fc);
      @(negedge clk);
   endtask
   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
   endtask
   task automatic set_lw(input logic [4:0] wn);
      ctrl_t c;
      rand_id();
      c = '0; c.RegWrite = 1; c.MemRead = 1; c.MemtoReg = 1; c.ALUSrc = 1;
      bus.instr_id = {OP_LW, 5'd0, wn, 16'd0};
      bus.read_num1_id = 0; bus.use_rs_id = 1; bus.use_rt_id = 0;
      bus.write_num_id = wn; bus.ctrl_id = c;
   endtask
   task automatic set_add(input logic [4:0] r1, input bit urs);
      ctrl_t c;
      rand_id();
      c = '0; c.RegWrite = 1; c.ALUOp = 4'd2;
      bus.instr_id = {OP_RTYPE, r1, 5'd10, 5'd9, 5'd0, 6'h20};
      bus.read_num1_id = r1; bus.use_rs_id = urs;
      bus.read_num2_id = 5'd10; bus.use_rt_id = 1;
      bus.write_num_id = 5'd9; bus.ctrl_id = c;
   endtask
   initial begin
      ctrl_t c;
      logic [31:0] held;
      rand_id();
      set_ctl(0, 0, 0);
      @(negedge clk);
      do_reset();
      chk("rst_valid", bus.valid_ex, 0);
      c = '0; c.RegWrite = 1; c.ALUSrc = 1;
      rand_id();
      bus.instr_id = 32'h20080005; bus.write_num_id = 5'd8; bus.ctrl_id = c;
      bus.use_rt_id = 0;
      tick();
      chk("addi_instr", bus.instr_ex, 32'h20080005);
      chk("addi_valid", bus.valid_ex, 1);
      chk("addi_sc", bus.stall_cycles, 0);
      set_lw(5'd8);
      tick();
      set_add(5'd8, 1);
      #1 chk("lu_stall", bus.stall_if_id, 1);
      tick();
      chk("lu_bubble", bus.valid_ex, 0);
      tick();
      chk("lu_add", bus.instr_ex, 32'h010A4820);
      chk("lu_sc", bus.stall_cycles, 1);
      set_lw(5'd0);
      tick();
      set_add(5'd0, 1);
      #1 chk("r0_nostall", bus.stall_if_id, 0);
      tick();
      set_lw(5'd8);
      tick();
      set_add(5'd8, 0);
      bus.use_rt_id = 0;
      #1 chk("nors_nostall", bus.stall_if_id, 0);
      tick();
      do_reset();
      set_lw(5'd8);
      tick();
      set_add(5'd8, 1);
      set_ctl(1, 1, 0);
      #1 chk("flush_stall_ext", bus.stall_if_id, 1);
      tick();
      chk("flush_valid", bus.valid_ex, 0);
      chk("flush_fc", bus.flush_cycles, 1);
      chk("flush_sc", bus.stall_cycles, 0);
      set_ctl(0, 0, 0);
      set_add(5'd3, 1);
      held = bus.instr_id;
      tick();
      for (int i = 0; i < 3; i++) begin
         rand_id();
         set_ctl(0, 1, 0);
         #1 chk("hold_stall", bus.stall_if_id, 1);
         tick();
         chk("hold_instr", bus.instr_ex, held);
      end
      set_ctl(0, 0, 1);
      rand_id();
      tick();
      set_ctl(0, 0, 0);
      for (int i = 0; i < 5; i++) begin
         rand_id();
         tick();
         chk("halt_valid", bus.valid_ex, 0);
         chk("halt_instr", bus.instr_ex, 0);
      end
      do_reset();
      rand_id();
      tick();
      chk("post_halt_valid", bus.valid_ex, 1);
      for (int i = 0; i < SAT + 5; i++) begin
         rand_id();
         set_ctl(1, 0, 0);
         tick();
      end
      chk("flush_sat", bus.flush_cycles, SAT);
      set_ctl(0, 0, 0);
      for (int i = 0; i < SAT + 5; i++) begin
         set_lw(5'd8);
         tick();
         set_add(5'd8, 1);
         tick();
         tick();
      end
      chk("stall_sat", bus.stall_cycles, SAT);
      for (int i = 0; i < 3000; i++) begin
         rand_id();
         c = bus.ctrl_id;
         c.MemRead = ($urandom_range(0, 2) == 0);
         bus.ctrl_id = c;
         bus.valid_id = ($urandom_range(0, 7) != 0);
         if ($urandom_range(0, 1) == 1) bus.read_num1_id = m.wn;
         if ($urandom_range(0, 3) == 1) bus.read_num2_id = m.wn;
         set_ctl($urandom_range(0, 9) == 0, $urandom_range(0, 6) == 0, $urandom_range(0, 199) == 0);
         rst_n = ($urandom_range(0, 49) != 0);
         tick();
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
